// File: rtl/mema_row_packer.sv
// rtl/mema_row_packer.sv - packs input chunks into wide matrix-A memory rows
// Optional: define MEMA_ROW_PACKER_PAD_CHECK_EN to flag nonzero padding in partial chunks.
module mema_row_packer #(
  parameter int no_of_elements_on_col_nos   = 20,
  parameter int no_of_row_by_vector_modules = 4,
  parameter int element_width               = 32,
  parameter int no_of_units                 = no_of_row_by_vector_modules*2,
  parameter int memory_A_height             = 2000,
  parameter int address_width               = $clog2(memory_A_height)+1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [address_width-1:0]              base_address,
  input  logic [address_width-1:0]              row_count,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [no_of_units*element_width-1:0]  in_data,
  output logic                                  memA_write_enable,
  output logic [address_width-1:0]              memA_write_address,
  output logic [no_of_row_by_vector_modules*no_of_elements_on_col_nos*element_width-1:0] memA_write_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pad_error
);
  localparam int N                  = no_of_elements_on_col_nos;
  localparam int M                  = no_of_row_by_vector_modules;
  localparam int W                  = element_width;
  localparam int U                  = no_of_units;
  localparam int chunks_per_segment = (N + U - 1) / U;
  localparam int overflow_allowed   = N % U;
  localparam int row_width          = M * N * W;
  localparam int CHUNK_W            = U * W;
  localparam int KEEP_W             = (overflow_allowed == 0) ? CHUNK_W : overflow_allowed * W;
  localparam int PAD_W              = (overflow_allowed == 0) ? 1 : CHUNK_W - KEEP_W;
  localparam int IDX_W              = $clog2(row_width);
  localparam int SEG_W              = $clog2(M + 1);
  localparam int CH_W               = $clog2(chunks_per_segment + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]               r_state;
  logic [SEG_W-1:0]         r_seg;
  logic [CH_W-1:0]          r_chunk;
  logic [address_width-1:0] r_addr;
  logic [address_width-1:0] r_remaining;
  logic [row_width-1:0]     r_row;
  logic                     r_done;

  logic                     w_last_chunk;
  logic                     w_last_seg;
  logic                     w_partial;
  int                       w_top_full;
  logic [IDX_W-1:0]         w_top;
  logic [row_width-1:0]     w_row_next;

  // r_seg counts up from 0 while the segment number m runs M down to 1
  assign w_last_chunk = (r_chunk == CH_W'(chunks_per_segment - 1));
  assign w_last_seg   = (r_seg == SEG_W'(M - 1));
  assign w_partial    = w_last_chunk && (overflow_allowed != 0);
  assign w_top_full   = ((M - int'(r_seg)) * N - int'(r_chunk) * U) * W - 1;
  assign w_top        = w_top_full[IDX_W-1:0];

  always_comb begin
    w_row_next = r_row;
    if (w_partial)
      w_row_next[w_top -: KEEP_W] = in_data[CHUNK_W-1 -: KEEP_W];
    else
      w_row_next[w_top -: CHUNK_W] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seg       <= '0;
      r_chunk     <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_row       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (row_count != '0) begin
              r_addr      <= base_address;
              r_remaining <= row_count;
              r_seg       <= '0;
              r_chunk     <= '0;
              r_state     <= S_FILL;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (in_valid) begin
            r_row <= w_row_next;
            if (w_last_chunk) begin
              r_chunk <= '0;
              if (w_last_seg) begin
                r_seg   <= '0;
                r_state <= S_WRITE;
              end else begin
                r_seg <= r_seg + SEG_W'(1);
              end
            end else begin
              r_chunk <= r_chunk + CH_W'(1);
            end
          end
        end
        S_WRITE: begin
          r_addr      <= (r_addr == address_width'(memory_A_height)) ? '0 : r_addr + address_width'(1);
          r_remaining <= r_remaining - address_width'(1);
          if (r_remaining == address_width'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEMA_ROW_PACKER_PAD_CHECK_EN
  logic r_pad_error;
  logic w_pad_bad;

  assign w_pad_bad = (r_state == S_FILL) && in_valid && w_partial && (|in_data[PAD_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pad_error <= 1'b0;
    else if (r_state == S_IDLE && start)
      r_pad_error <= 1'b0;
    else if (w_pad_bad)
      r_pad_error <= 1'b1;
  end

  assign pad_error = r_pad_error;
`else
  assign pad_error = 1'b0;
`endif

  assign in_ready           = (r_state == S_FILL);
  assign memA_write_enable  = (r_state == S_WRITE);
  assign memA_write_address = r_addr;
  assign memA_write_data    = r_row;
  assign busy               = (r_state != S_IDLE);
  assign done               = r_done;

endmodule

// File: doc/mema_row_packer.md
# mema_row_packer

Write-side companion of the matrix-A row memory. Accepts a stream of fixed-width chunks (no_of_units elements each) and packs them into one wide memory row. The layout is exactly the one the matrix-A chunk reader slices back out per row-by-vector module. Each completed row is written to consecutive row addresses starting at a programmed base, with a valid/ready handshake on the input and a single-cycle write strobe on the memory side.

## Interface
Parameters:
- no_of_elements_on_col_nos, 20, elements per module segment of a row (N)
- no_of_row_by_vector_modules, 4, segments per row (M)
- element_width, 32, bits per element (W)
- no_of_units, no_of_row_by_vector_modules*2, elements per input chunk (U)
- memory_A_height, 2000, highest valid row address
- address_width, $clog2(memory_A_height)+1, row address width

Derived (localparam):
- chunks_per_segment = ceil(N/U)
- overflow_allowed = N % U
- row_width = M*N*W

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches base_address and row_count
- base_address  in  address_width  first row address to write
- row_count  in  address_width  number of rows to write
- in_valid  in  1  chunk present on in_data
- in_ready  out  1  block accepts chunk this cycle
- in_data  in  U*W  chunk; element 0 in the most-significant W bits
- memA_write_enable  out  1  one-cycle write strobe
- memA_write_address  out  address_width  row address for the strobe
- memA_write_data  out  row_width  packed row
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last row write
- pad_error  out  1  sticky padding violation (see Configuration)

## Operation
- States: IDLE, FILL, WRITE.
- IDLE: in_ready=0. A start pulse with row_count>0 latches the base address and count and enters FILL. A start pulse with row_count=0 pulses done the next cycle and stays in IDLE.
- FILL: in_ready=1. Each beat (in_valid&in_ready) stores one chunk.
  - Chunks arrive segment m=M down to 1, chunk c=1..chunks_per_segment within each segment.
  - Chunk (m,c) occupies row bits [(m*N-(c-1)*U)*W-1 -: U*W].
  - When c=chunks_per_segment and overflow_allowed≠0, only the upper overflow_allowed*W bits of in_data are stored. The lower bits are discarded.
  - After M*chunks_per_segment beats, go to WRITE.
- WRITE: in_ready=0. memA_write_enable=1 for exactly one cycle, with the current address and the full row.
  - Address then increments; it wraps to 0 after memory_A_height.
  - The remaining count decrements. If it is nonzero, return to FILL with cleared segment/chunk counters. If it is zero, go to IDLE and pulse done.
- start while busy is ignored.
- Row register holds its value between writes; it is not cleared per row.

## Timing
- Reset values: in_ready=0, memA_write_enable=0, memA_write_address=0, memA_write_data=0, busy=0, done=0, pad_error=0. Internal state is IDLE with counters at 0.
- start sampled at cycle t sets busy and in_ready at t+1.
- A beat accepted at cycle t is visible in memA_write_data at t+1.
- The last beat of a row accepted at t gives memA_write_enable=1 at t+1 and in_ready=1 again at t+2. Row throughput is M*chunks_per_segment+1 cycles.
- done asserts in the cycle after the final write strobe; busy falls in that same cycle.
- in_valid low stalls the block with no state change; there is no timeout.
- rst_n low mid-row: the partial row is abandoned and no write occurs. Outputs return to reset values immediately.

## Configuration
- MEMA_ROW_PACKER_PAD_CHECK_EN defined:
  - On every partial final chunk (overflow_allowed≠0), any nonzero bit in the discarded lower (U-overflow_allowed)*W bits sets pad_error.
  - pad_error stays set until rst_n or the next accepted start.
  - Data is still written normally.
- Not defined: no check logic; pad_error tied 0.

## Test plan
- Defaults (N=20, U=8, M=4). start with base=5, row_count=1, then 12 beats, each element = (segment<<8)|element index. Required: one strobe at address 5. Row bits [2559-:32]=0x400 and bits [31:0]=0x113. Padding elements are dropped. done follows one cycle later.
- row_count=3, base=memory_A_height-1, in_valid always high. Required: strobes at 1999, 2000, 0; 13-cycle spacing; in_ready low only on strobe cycles.
- in_valid toggled 1010… during a row. Required: identical memA_write_data to the unstalled run, with the strobe delayed by the stall cycles.
- rst_n pulsed low after beat 7 of a row. Required: no strobe; all outputs at reset values. A new start, row_count=1, with 12 beats writes a correct row.
- start with row_count=0. Required: done pulse the next cycle, no strobe, busy stays 0. A second start during busy is ignored, with no change to address or count.
- With MEMA_ROW_PACKER_PAD_CHECK_EN: last chunk of segment 4 with lower padding element = 0xDEAD. Required: pad_error=1 the next cycle, held until the next start. Without the macro: pad_error stays 0.
